// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular FIFO of pending doubleword stores that drains to one data-memory port.
// Define STORE_FWD_EN for store-to-load forwarding; without it, a load matching a pending store stalls.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   st_valid,
   input  logic [AW-1:0]          st_addr,
   input  logic [63:0]            st_data,
   output logic                   st_ready,
   input  logic                   ld_valid,
   input  logic [AW-1:0]          ld_addr,
   output logic                   ld_hit,
   output logic [63:0]            ld_fwd_data,
   output logic                   ld_stall,
   output logic [AW-1:0]          mem_address,
   output logic [63:0]            mem_write_data,
   output logic                   mem_write,
   output logic                   mem_read,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [63:0]   data_q [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;

   logic          match;
   logic [63:0]   match_data;
   logic [PW-1:0] idx;
   logic          enq, drain;

   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Store handshake: a store transfers on a rising edge where st_valid && st_ready;
   // st_ready depends only on occupancy, and upstream holds st_valid/st_addr/st_data until then.
   assign st_ready = !full;
   assign enq      = st_valid && !full;

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      match      = 1'b0;
      match_data = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
            match      = 1'b1;
            match_data = data_q[idx];
         end
      end
   end

`ifdef STORE_FWD_EN
   assign ld_hit      = ld_valid && match;
   assign ld_fwd_data = ld_hit ? match_data : '0;
   assign ld_stall    = 1'b0;
`else
   assign ld_hit      = 1'b0;
   assign ld_fwd_data = '0;
   assign ld_stall    = ld_valid && match;
`endif

   // A stalled load gives the port back to the drain so the matching entry can retire.
   assign drain          = !empty && (!ld_valid || ld_stall);
   assign mem_write      = drain;
   assign mem_read       = reset_n && ld_valid && !ld_stall;
   assign mem_address    = drain ? addr_q[head_q] : (mem_read ? ld_addr : '0);
   assign mem_write_data = drain ? data_q[head_q] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq)
            tail_q <= tail_q + 1'b1;
         if (drain)
            head_q <= head_q + 1'b1;
         count_q <= count_q + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, drain};
      end
   end

   // Entry payloads are qualified by count, so they carry no reset.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail_q] <= st_addr;
         data_q[tail_q] <= st_data;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue of pending {addr,data} stores predicts every output each cycle;
// scenario tasks cover reset, single store, fill, forwarding/stall, wrap, random traffic and mid-drain reset.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 64;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int W     = AW + 64;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          st_valid = 1'b0;
   logic [AW-1:0] st_addr = '0;
   logic [63:0]   st_data = '0;
   logic          st_ready;
   logic          ld_valid = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic          ld_hit;
   logic [63:0]   ld_fwd_data;
   logic          ld_stall;
   logic [AW-1:0] mem_address;
   logic [63:0]   mem_write_data;
   logic          mem_write;
   logic          mem_read;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   int total = 0;
   int bad = 0;
   int writes_seen = 0;

   // Pending stores, oldest first, packed as {addr, data}.
   logic [W-1:0] exp_q[$];

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
      .ld_stall(ld_stall), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .count(count), .full(full), .empty(empty)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic bit model_match(input logic [AW-1:0] a, output logic [63:0] d);
      bit m = 1'b0;
      d = '0;
      foreach (exp_q[i]) begin
         if (exp_q[i][W-1:64] == a) begin
            m = 1'b1;
            d = exp_q[i][63:0];
         end
      end
      return m;
   endfunction

   function automatic bit exp_stall();
      logic [63:0] d;
      bit m;
      m = model_match(ld_addr, d);
`ifdef STORE_FWD_EN
      return 1'b0 && m;
`else
      return ld_valid && m;
`endif
   endfunction

   function automatic bit exp_drain();
      return (exp_q.size() > 0) && (!ld_valid || exp_stall());
   endfunction

   always @(negedge reset_n) exp_q.delete();

   always @(posedge clk) begin
      if (reset_n) begin
         bit acc, drn;
         acc = st_valid && (exp_q.size() < DEPTH);
         drn = exp_drain();
         if (drn) void'(exp_q.pop_front());
         if (acc) exp_q.push_back({st_addr, st_data});
      end
   end

   // ---------------- scoreboard: every output every cycle ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         logic [63:0]   md, e_wdata, e_fwd;
         logic [AW-1:0] e_addr;
         logic [CW+6:0] e_flags, a_flags;
         bit m, e_stall, e_drain, e_read, e_hit;
         int n;
         n       = exp_q.size();
         m       = model_match(ld_addr, md);
         e_stall = exp_stall();
         e_drain = exp_drain();
         e_read  = ld_valid && !e_stall;
`ifdef STORE_FWD_EN
         e_hit   = ld_valid && m;
`else
         e_hit   = 1'b0;
`endif
         e_fwd   = e_hit ? md : 64'd0;
         e_addr  = e_drain ? exp_q[0][W-1:64] : (e_read ? ld_addr : '0);
         e_wdata = e_drain ? exp_q[0][63:0] : 64'd0;
         e_flags = {CW'(n), n == 0, n == DEPTH, n != DEPTH, e_drain, e_read, e_hit, e_stall};
         a_flags = {count, empty, full, st_ready, mem_write, mem_read, ld_hit, ld_stall};
         if (mem_write === 1'b1) writes_seen++;
         total++;
         if (a_flags !== e_flags) begin
            bad++;
            $display("FAIL sb_flags t=%0t {count,empty,full,st_ready,mem_write,mem_read,ld_hit,ld_stall} got=%b want=%b",
                     $time, a_flags, e_flags);
         end
         total++;
         if (mem_address !== e_addr) begin
            bad++;
            $display("FAIL sb_mem_address t=%0t got=%0h want=%0h", $time, mem_address, e_addr);
         end
         total++;
         if (mem_write_data !== e_wdata) begin
            bad++;
            $display("FAIL sb_mem_write_data t=%0t got=%0h want=%0h", $time, mem_write_data, e_wdata);
         end
`ifdef STORE_FWD_EN
         if (e_hit) begin
`else
         begin
`endif
            total++;
            if (ld_fwd_data !== e_fwd) begin
               bad++;
               $display("FAIL sb_ld_fwd_data t=%0t got=%0h want=%0h", $time, ld_fwd_data, e_fwd);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input bit sv, input logic [AW-1:0] sa, input logic [63:0] sd,
                       input bit lv, input logic [AW-1:0] la);
      @(posedge clk);
      #1;
      st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la;
      @(negedge clk);
   endtask

   task automatic drain_idle(input string who);
      int guard = 0;
      step(0, '0, '0, 0, '0);
      while (empty !== 1'b1 && guard < 20) begin
         step(0, '0, '0, 0, '0);
         guard++;
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL %s_drain_timeout empty got=%b want=1", who, empty);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      st_valid = 1'b1; st_addr = 64'h40; st_data = 64'h55;
      ld_valid = 1'b1; ld_addr = 64'h40;
      #2;
      total++;
      if ({count, empty, full, st_ready} !== {CW'(0), 3'b101}) begin
         bad++;
         $display("FAIL reset_occupancy {count,empty,full,st_ready} got=%b want=%b",
                  {count, empty, full, st_ready}, {CW'(0), 3'b101});
      end
      total++;
      if ({mem_write, mem_read, ld_hit, ld_stall} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_port {mem_write,mem_read,ld_hit,ld_stall} got=%b want=0000",
                  {mem_write, mem_read, ld_hit, ld_stall});
      end
      @(negedge clk);
      total++;
      if (count !== CW'(0)) begin
         bad++;
         $display("FAIL reset_hold_count got=%0d want=0", count);
      end
      st_valid = 1'b0; ld_valid = 1'b0; ld_addr = '0;
      #2 reset_n = 1'b1;
   endtask

   task automatic test_single_store();
      step(1, 64'h10, 64'hAA, 0, '0);
      total++;
      if (mem_write !== 1'b0) begin
         bad++;
         $display("FAIL single_same_cycle mem_write got=%b want=0", mem_write);
      end
      step(0, '0, '0, 0, '0);
      total++;
      if ({mem_write, mem_address, mem_write_data} !== {1'b1, 64'h10, 64'hAA}) begin
         bad++;
         $display("FAIL single_write got=%b/%0h/%0h want=1/10/aa", mem_write, mem_address, mem_write_data);
      end
      step(0, '0, '0, 0, '0);
      total++;
      if ({empty, mem_write, mem_address} !== {1'b1, 1'b0, 64'h0}) begin
         bad++;
         $display("FAIL single_after empty/mem_write/addr got=%b/%b/%0h want=1/0/0", empty, mem_write, mem_address);
      end
   endtask

   task automatic test_fill();
      int w0;
      for (int i = 0; i < 4; i++) step(1, 64'(i * 8), 64'(100 + i), 1, 64'h100);
      step(1, 64'h20, 64'h999, 1, 64'h100);
      total++;
      if ({full, st_ready, count} !== {1'b1, 1'b0, CW'(4)}) begin
         bad++;
         $display("FAIL fill_full full/st_ready/count got=%b/%b/%0d want=1/0/4", full, st_ready, count);
      end
      total++;
      if ({mem_write, mem_read, mem_address} !== {2'b01, 64'h100}) begin
         bad++;
         $display("FAIL fill_load_port got=%b/%b/%0h want=0/1/100", mem_write, mem_read, mem_address);
      end
      step(0, '0, '0, 1, 64'h100);
      total++;
      if (count !== CW'(4)) begin
         bad++;
         $display("FAIL fill_fifth_rejected count got=%0d want=4", count);
      end
      w0 = writes_seen;
      drain_idle("fill");
      total++;
      if (writes_seen - w0 !== 4) begin
         bad++;
         $display("FAIL fill_write_count got=%0d want=4", writes_seen - w0);
      end
   endtask

   task automatic test_forward();
      step(1, 64'h20, 64'h11, 1, 64'h200);
      step(1, 64'h20, 64'h22, 1, 64'h200);
      step(0, '0, '0, 1, 64'h20);
`ifdef STORE_FWD_EN
      total++;
      if ({ld_hit, ld_fwd_data, mem_write, ld_stall} !== {1'b1, 64'h22, 2'b00}) begin
         bad++;
         $display("FAIL fwd_youngest hit/data/mem_write/stall got=%b/%0h/%b/%b want=1/22/0/0",
                  ld_hit, ld_fwd_data, mem_write, ld_stall);
      end
`else
      total++;
      if ({ld_stall, mem_read, mem_write, mem_write_data} !== {3'b101, 64'h11}) begin
         bad++;
         $display("FAIL stall_first stall/read/write/data got=%b/%b/%b/%0h want=1/0/1/11",
                  ld_stall, mem_read, mem_write, mem_write_data);
      end
      step(0, '0, '0, 1, 64'h20);
      total++;
      if ({ld_stall, mem_write, mem_write_data} !== {2'b11, 64'h22}) begin
         bad++;
         $display("FAIL stall_second stall/write/data got=%b/%b/%0h want=1/1/22", ld_stall, mem_write, mem_write_data);
      end
      step(0, '0, '0, 1, 64'h20);
      total++;
      if ({ld_stall, mem_read, mem_address} !== {2'b01, 64'h20}) begin
         bad++;
         $display("FAIL stall_release stall/read/addr got=%b/%b/%0h want=0/1/20", ld_stall, mem_read, mem_address);
      end
`endif
      drain_idle("fwd");
      step(1, 64'h28, 64'h33, 1, 64'h200);
      step(0, '0, '0, 1, 64'h28);
`ifdef STORE_FWD_EN
      total++;
      if ({ld_hit, ld_fwd_data} !== {1'b1, 64'h33}) begin
         bad++;
         $display("FAIL fwd_single hit/data got=%b/%0h want=1/33", ld_hit, ld_fwd_data);
      end
`else
      total++;
      if ({ld_stall, mem_read, mem_write, mem_address} !== {3'b101, 64'h28}) begin
         bad++;
         $display("FAIL stall_single stall/read/write/addr got=%b/%b/%b/%0h want=1/0/1/28",
                  ld_stall, mem_read, mem_write, mem_address);
      end
      step(0, '0, '0, 1, 64'h28);
      total++;
      if ({ld_stall, mem_read, mem_address, ld_hit} !== {2'b01, 64'h28, 1'b0}) begin
         bad++;
         $display("FAIL stall_single_release stall/read/addr/hit got=%b/%b/%0h/%b want=0/1/28/0",
                  ld_stall, mem_read, mem_address, ld_hit);
      end
`endif
      drain_idle("fwd2");
   endtask

   task automatic test_wrap();
      int w0;
      w0 = writes_seen;
      for (int i = 0; i < 10; i++) step(1, 64'(16'h1000 + i * 8), 64'(16'hC000 + i), 0, '0);
      drain_idle("wrap");
      total++;
      if (writes_seen - w0 !== 10) begin
         bad++;
         $display("FAIL wrap_write_count got=%0d want=10", writes_seen - w0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 64'($urandom_range(0, 7)) << 3, {$urandom, $urandom},
              $urandom_range(0, 2) == 0, 64'($urandom_range(0, 7)) << 3);
      end
      drain_idle("random");
   endtask

   task automatic test_reset_mid();
      int w0;
      for (int i = 0; i < 3; i++) step(1, 64'(16'h2000 + i * 8), 64'(i + 7), 1, 64'h300);
      step(0, '0, '0, 0, '0);
      total++;
      if ({count, mem_write} !== {CW'(3), 1'b1}) begin
         bad++;
         $display("FAIL rmid_pre count/mem_write got=%0d/%b want=3/1", count, mem_write);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({count, empty, mem_write, full, st_ready} !== {CW'(0), 4'b1001}) begin
         bad++;
         $display("FAIL rmid_async {count,empty,mem_write,full,st_ready} got=%b want=%b",
                  {count, empty, mem_write, full, st_ready}, {CW'(0), 4'b1001});
      end
      @(negedge clk);
      #1 reset_n = 1'b1;
      w0 = writes_seen;
      for (int i = 0; i < 4; i++) step(0, '0, '0, 0, '0);
      total++;
      if (writes_seen - w0 !== 0 || count !== CW'(0)) begin
         bad++;
         $display("FAIL rmid_no_writes writes/count got=%0d/%0d want=0/0", writes_seen - w0, count);
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_fill();
      test_forward();
      test_wrap();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of buffered stores; legal values are 2, 4 and 8.
REQ-002 Parameter AW, default 64, is the byte address width.
REQ-003 clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-004 reset_n  input  1  is the reset, asynchronous and active-low.
REQ-005 st_valid  input  1  requests a store from the EX/MEM register.
REQ-006 st_addr  input  AW  is the store byte address (8-byte doubleword).
REQ-007 st_data  input  64  is the store doubleword.
REQ-008 st_ready  output  1  means a store is accepted this cycle; it equals !full.
REQ-009 ld_valid  input  1  requests a load from the EX/MEM register.
REQ-010 ld_addr  input  AW  is the load byte address.
REQ-011 ld_hit  output  1  means the load is served from the buffer.
REQ-012 ld_fwd_data  output  64  is the forwarded doubleword, valid when ld_hit=1.
REQ-013 ld_stall  output  1  requests that the pipeline hold the load.
REQ-014 mem_address  output  AW  drives data-memory address.
REQ-015 mem_write_data  output  64  drives data-memory write_data.
REQ-016 mem_write  output  1  drives data-memory memorywrite.
REQ-017 mem_read  output  1  drives data-memory memoryread.
REQ-018 count  output  $clog2(DEPTH)+1  is the number of occupied entries.
REQ-019 full  output  1  is set when count==DEPTH.
REQ-020 empty  output  1  is set when count==0.

Function
REQ-021 The buffer is a circular FIFO with head and tail pointers that wrap modulo DEPTH.
- Each entry holds {addr, data}.
REQ-022 Enqueue: on a rising edge with st_valid && !full, the store is written at tail and tail advances.
- st_valid while full is ignored; upstream holds it.
REQ-023 Drain: when !empty && !ld_valid, the entry at head drives the memory port.
- mem_write=1, mem_address=head.addr, mem_write_data=head.data.
- head advances on the same rising edge that memory captures the write.
REQ-024 Loads have port priority: while ld_valid=1, mem_write=0, mem_read=1 and mem_address=ld_addr.
REQ-025 When the port is idle (empty, no load), mem_write=0, mem_read=0, mem_address=0 and mem_write_data=0.
REQ-026 Minimum latency from store acceptance to memory write is one cycle; a store is never drained in its acceptance cycle.
REQ-027 Simultaneous enqueue and drain leaves count unchanged.
- full blocks enqueue even in a cycle that also drains.
REQ-028 Address match compares the full AW-bit address for equality against occupied entries only.
- The store being accepted in the same cycle is not included in the match.
REQ-029 Simultaneous st_valid and ld_valid: both are processed.
- The load does not observe the concurrently accepted store.
REQ-030 ld_hit, ld_fwd_data and ld_stall are combinational from ld_valid, ld_addr and registered state.
REQ-031 Empty and full are exact at wrap-around; count is the sole occupancy source, so there is no pointer-equality ambiguity.

Reset
REQ-032 While reset_n=0, asynchronously:
- head=0, tail=0, count=0, all entries invalid.
- mem_write=0, mem_read=0, ld_hit=0, ld_stall=0.
- empty=1, full=0, st_ready=1.
REQ-033 Reset asserted mid-drain discards all pending stores; no further memory write is issued.
REQ-034 Stored entry addr/data contents need not be cleared.

Configuration
REQ-035 Macro STORE_FWD_EN defined: ld_valid with a matching occupied entry gives ld_hit=1 and ld_fwd_data=data of the youngest match; ld_stall=0.
REQ-036 Macro STORE_FWD_EN undefined:
- ld_hit=0 and ld_fwd_data=0 always.
- A matching ld_valid asserts ld_stall=1 and drives mem_read=0.
- The head is permitted to drain during ld_stall.
- ld_stall stays asserted until no occupied entry matches.

Verification
REQ-037 Reset, then st 0x10/0xAA one cycle with no load -> next cycle mem_write=1, address 0x10, data 0xAA; following cycle empty=1.
REQ-038 With DEPTH=4 and ld_valid held, four stores 0x0..0x18 fill the buffer -> full=1, st_ready=0; a fifth store is not accepted and count stays 4.
REQ-039 STORE_FWD_EN defined, stores 0x20/0x11 then 0x20/0x22 pending, load 0x20 -> ld_hit=1, ld_fwd_data=0x22, mem_write=0.
REQ-040 STORE_FWD_EN undefined, store 0x28/0x33 pending, load 0x28 -> ld_stall=1 until the entry drains, then mem_read=1 with address 0x28.
REQ-041 Push and drain ten stores continuously with DEPTH=4 -> memory writes occur in FIFO order across pointer wrap, with no loss or duplication.
REQ-042 Assert reset_n=0 with count=3 mid-drain -> immediately count=0, empty=1, mem_write=0; no further writes after release.
